// File: rtl/tdc_rr_arbiter.sv
// Round-robin merge of NUM_CH TDC channels into one FIFO write port, with a one-entry buffer
// per channel. Optional per-channel drop counters when TDC_RR_ARBITER_DROP_COUNT_EN is defined.
module tdc_rr_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 68,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic [NUM_CH-1:0]          ch_ready,
  input  logic [NUM_CH-1:0]          enable_channels,
  input  logic                       fifo_full,
  output logic                       fifo_write,
  output logic [DATA_W-1:0]          fifo_data,
  output logic [NUM_CH-1:0]          grant_onehot,
  input  logic                       clear_counts,
  output logic [NUM_CH*CNT_W-1:0]    drop_count
);

  localparam int unsigned PtrW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]             buf_valid_q;
  logic [NUM_CH-1:0][DATA_W-1:0] buf_data_q;
  logic [PtrW-1:0]               ptr_q;
  logic [PtrW-1:0]               winner;

  // Search starts one past the last grant, wrapping, so every channel gets a turn.
  always_comb begin
    logic found;
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      idx = (int'(ptr_q) + off) % NUM_CH;
      if (!found && buf_valid_q[idx]) begin
        found  = 1'b1;
        winner = PtrW'(idx);
      end
    end
  end

  assign ch_ready     = enable_channels & ~buf_valid_q;
  assign fifo_write   = (|buf_valid_q) & ~fifo_full;
  assign fifo_data    = fifo_write ? buf_data_q[winner] : '0;
  assign grant_onehot = fifo_write ? (NUM_CH'(1) << winner) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= '0;
      ptr_q       <= PtrW'(NUM_CH - 1);
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        // Disable flushes; a drained buffer cannot refill in the same cycle.
        if (!enable_channels[i]) begin
          buf_valid_q[i] <= 1'b0;
        end else if (fifo_write && (winner == PtrW'(i))) begin
          buf_valid_q[i] <= 1'b0;
        end else if (ch_valid[i] && ch_ready[i]) begin
          buf_valid_q[i] <= 1'b1;
        end
      end
      if (fifo_write) begin
        ptr_q <= winner;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!reset && ch_valid[i] && ch_ready[i]) begin
        buf_data_q[i] <= ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef TDC_RR_ARBITER_DROP_COUNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear_counts) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i] && enable_channels[i] && buf_valid_q[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign drop_count = cnt_q;
`else
  logic unused_clear_counts;
  assign unused_clear_counts = clear_counts;
  assign drop_count          = '0;
`endif

endmodule

// File: tb/tb_tdc_rr_arbiter.sv
// Directed bench for tdc_rr_arbiter; expected FIFO writes are queued as stimulus is driven.
module tb_tdc_rr_arbiter;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DATA_W = 68;
  localparam int unsigned CNT_W  = 16;
`ifdef TDC_RR_ARBITER_DROP_COUNT_EN
  localparam int unsigned ExpDrops = 3;
`else
  localparam int unsigned ExpDrops = 0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [NUM_CH-1:0] grant;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        ch_valid;
  logic [DATA_W-1:0]        d0, d1;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH-1:0]        enable_channels;
  logic                     fifo_full;
  logic                     fifo_write;
  logic [DATA_W-1:0]        fifo_data;
  logic [NUM_CH-1:0]        grant_onehot;
  logic                     clear_counts;
  logic [NUM_CH*CNT_W-1:0]  drop_count;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  assign ch_data = {d1, d0};

  tdc_rr_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .ch_valid        (ch_valid),
    .ch_data         (ch_data),
    .ch_ready        (ch_ready),
    .enable_channels (enable_channels),
    .fifo_full       (fifo_full),
    .fifo_write      (fifo_write),
    .fifo_data       (fifo_data),
    .grant_onehot    (grant_onehot),
    .clear_counts    (clear_counts),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] data, input logic [NUM_CH-1:0] grant);
    exp_t e;
    e.data  = data;
    e.grant = grant;
    exp_q.push_back(e);
  endtask

  // Check outputs at the falling edge, then advance to just after the next rising edge.
  task automatic cycle(input bit exp_write);
    exp_t e;
    @(negedge clk);
    chk("fifo_write", 128'(fifo_write), 128'(exp_write));
    if (exp_write) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("fifo_data", 128'(fifo_data), 128'(e.data));
        chk("grant_onehot", 128'(grant_onehot), 128'(e.grant));
      end
    end else begin
      chk("idle_data", 128'(fifo_data), 128'(0));
      chk("idle_grant", 128'(grant_onehot), 128'(0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ch_valid = '0; d0 = '0; d1 = '0; enable_channels = 2'b11;
    fifo_full = 1'b0; clear_counts = 1'b0;
    @(posedge clk); #1;
    cycle(1'b0);
    chk("reset_ready", 128'(ch_ready), 128'(2'b11));
    chk("reset_drop", 128'(drop_count), 128'(0));
    reset = 1'b0;

    // Single event, one cycle latency.
    ch_valid = 2'b01; d0 = 68'h1; push(68'h1, 2'b01);
    cycle(1'b0);
    ch_valid = '0;
    cycle(1'b1);
    cycle(1'b0);

    // Simultaneous events after reset: ch0 then ch1, twice.
    do_reset();
    ch_valid = 2'b11; d0 = 68'hA0A; d1 = 68'hB0B;
    push(68'hA0A, 2'b01); push(68'hB0B, 2'b10);
    cycle(1'b0);
    ch_valid = '0;
    cycle(1'b1);
    cycle(1'b1);
    ch_valid = 2'b11; d0 = 68'hC0C; d1 = 68'hD0D;
    push(68'hC0C, 2'b01); push(68'hD0D, 2'b10);
    cycle(1'b0);
    ch_valid = '0;
    cycle(1'b1);
    cycle(1'b1);

    // Backpressure holds ch1 and the pointer.
    fifo_full = 1'b1;
    ch_valid = 2'b10; d1 = 68'hF_0000_0000_0000_00E1; push(68'hF_0000_0000_0000_00E1, 2'b10);
    cycle(1'b0);
    ch_valid = '0;
    for (int i = 0; i < 5; i++) cycle(1'b0);
    chk("full_ready1", 128'(ch_ready[1]), 128'(0));
    fifo_full = 1'b0;
    cycle(1'b1);
    ch_valid = 2'b11; d0 = 68'h123; d1 = 68'h456;
    push(68'h123, 2'b01); push(68'h456, 2'b10);
    cycle(1'b0);
    ch_valid = '0;
    cycle(1'b1);
    cycle(1'b1);

    // Drops on a full buffer, then clear.
    fifo_full = 1'b1;
    ch_valid = 2'b01; d0 = 68'h77;
    cycle(1'b0);
    d0 = 68'hDEAD;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    ch_valid = '0;
    cycle(1'b0);
    chk("drop0", 128'(drop_count[CNT_W-1:0]), 128'(ExpDrops));
    chk("drop1", 128'(drop_count[2*CNT_W-1:CNT_W]), 128'(0));
    clear_counts = 1'b1;
    cycle(1'b0);
    clear_counts = 1'b0;
    chk("drop_cleared", 128'(drop_count), 128'(0));
    fifo_full = 1'b0; push(68'h77, 2'b01);
    cycle(1'b1);

    // Disable flushes a buffered event; further valids ignored.
    fifo_full = 1'b1;
    ch_valid = 2'b10; d1 = 68'h99;
    cycle(1'b0);
    ch_valid = '0; enable_channels = 2'b01;
    #1;
    chk("disabled_ready", 128'(ch_ready), 128'(2'b01));
    cycle(1'b0);
    ch_valid = 2'b10;
    cycle(1'b0);
    cycle(1'b0);
    ch_valid = '0; fifo_full = 1'b0;
    cycle(1'b0);
    chk("disabled_drop1", 128'(drop_count[2*CNT_W-1:CNT_W]), 128'(0));
    chk("disabled_ready_hold", 128'(ch_ready), 128'(2'b01));
    enable_channels = 2'b11;

    // Reset with both buffers full and nonzero drop counts.
    fifo_full = 1'b1;
    ch_valid = 2'b11; d0 = 68'h5A; d1 = 68'h5B;
    cycle(1'b0);
    cycle(1'b0);
    ch_valid = '0;
    reset = 1'b1;
    cycle(1'b0);
    reset = 1'b0; fifo_full = 1'b0;
    chk("post_reset_drop", 128'(drop_count), 128'(0));
    chk("post_reset_ready", 128'(ch_ready), 128'(2'b11));
    cycle(1'b0);
    ch_valid = 2'b11; d0 = 68'h11; d1 = 68'h22;
    push(68'h11, 2'b01); push(68'h22, 2'b10);
    cycle(1'b0);
    ch_valid = '0;
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b0);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish by 100000");
    $fatal(1, "timeout");
  end

endmodule
